// File: rtl/mlp_layer_sequencer.sv
// One fully-connected MLP layer: streams activations and weights, accumulates
// dot product plus bias, applies optional ReLU and saturation, writes results back.
module mlp_layer_sequencer #(
   parameter int ADDR_W  = 12,
   parameter int DATA_W  = 16,
   parameter int WADDR_W = 16,
   parameter int ACC_W   = 40
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic [ADDR_W-1:0]         cfg_in_base,
   input  logic [ADDR_W-1:0]         cfg_in_count,
   input  logic [ADDR_W-1:0]         cfg_out_base,
   input  logic [ADDR_W-1:0]         cfg_out_count,
   input  logic [WADDR_W-1:0]        cfg_w_base,
   input  logic                      cfg_relu,
   output logic [ADDR_W-1:0]         nm_rd_addr,
   input  logic signed [DATA_W-1:0]  nm_rd_data,
   output logic                      nm_we,
   output logic [ADDR_W-1:0]         nm_wr_addr,
   output logic signed [DATA_W-1:0]  nm_wr_data,
   output logic [WADDR_W-1:0]        w_addr,
   input  logic signed [DATA_W-1:0]  w_data,
   output logic                      busy,
   output logic                      done,
   output logic                      cfg_err
);

   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DRAIN, S_WRITE, S_DONE} state_t;

   state_t                    state;
   logic [ADDR_W-1:0]         in_base;
   logic [ADDR_W-1:0]         in_count;
   logic [ADDR_W-1:0]         out_base;
   logic [ADDR_W-1:0]         out_count;
   logic                      relu_en;
   logic [ADDR_W-1:0]         idx;
   logic [ADDR_W-1:0]         j;
   logic signed [ACC_W-1:0]   acc;

   logic signed [2*DATA_W-1:0] prod;
   logic signed [ACC_W-1:0]    prod_ext;
   logic signed [ACC_W-1:0]    bias_ext;
   logic signed [ACC_W-1:0]    acc_sum;
   logic [ADDR_W-1:0]          d_io;
   logic [ADDR_W-1:0]          d_oi;
   logic                       cfg_ok;

   function automatic logic signed [ACC_W-1:0] relu_f(input logic signed [ACC_W-1:0] v,
                                                      input logic en);
      return (en && v[ACC_W-1]) ? '0 : v;
   endfunction

   function automatic logic signed [DATA_W-1:0] sat_f(input logic signed [ACC_W-1:0] v);
      if ((&v[ACC_W-1:DATA_W-1]) || !(|v[ACC_W-1:DATA_W-1]))
         return v[DATA_W-1:0];
      else if (v[ACC_W-1])
         return {1'b1, {(DATA_W-1){1'b0}}};
      else
         return {1'b0, {(DATA_W-1){1'b1}}};
   endfunction

   assign prod     = nm_rd_data * w_data;
   assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
   assign bias_ext = {{(ACC_W-DATA_W){w_data[DATA_W-1]}}, w_data};

   // Ranges are disjoint iff each base lies outside the other's span, measured modulo 2^ADDR_W.
   assign d_io   = cfg_out_base - cfg_in_base;
   assign d_oi   = cfg_in_base - cfg_out_base;
   assign cfg_ok = (cfg_in_count != '0) && (cfg_out_count != '0) &&
                   (d_io >= cfg_in_count) && (d_oi >= cfg_out_count);

   // In FETCH index 0 nothing has returned yet; later indices consume the previous product.
   always_comb begin
      acc_sum = acc;
      if (state == S_FETCH && idx != '0)
         acc_sum = acc + prod_ext;
      else if (state == S_DRAIN)
         acc_sum = acc + bias_ext;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         in_base    <= '0;
         in_count   <= '0;
         out_base   <= '0;
         out_count  <= '0;
         relu_en    <= 1'b0;
         idx        <= '0;
         j          <= '0;
         acc        <= '0;
         nm_rd_addr <= '0;
         nm_we      <= 1'b0;
         nm_wr_addr <= '0;
         nm_wr_data <= '0;
         w_addr     <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         cfg_err    <= 1'b0;
      end else begin
         done    <= 1'b0;
         cfg_err <= 1'b0;
         nm_we   <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  if (cfg_ok) begin
                     in_base    <= cfg_in_base;
                     in_count   <= cfg_in_count;
                     out_base   <= cfg_out_base;
                     out_count  <= cfg_out_count;
                     relu_en    <= cfg_relu;
                     idx        <= '0;
                     j          <= '0;
                     acc        <= '0;
                     nm_rd_addr <= cfg_in_base;
                     w_addr     <= cfg_w_base;
                     busy       <= 1'b1;
                     state      <= S_FETCH;
                  end else begin
                     cfg_err <= 1'b1;
                  end
               end
            end
            S_FETCH: begin
               acc <= acc_sum;
               if (idx == in_count) begin
                  state <= S_DRAIN;
               end else begin
                  idx    <= idx + 1'b1;
                  w_addr <= w_addr + 1'b1;
                  // Bias slot has no activation; the read address is left where it was.
                  if ((idx + 1'b1) != in_count)
                     nm_rd_addr <= nm_rd_addr + 1'b1;
               end
            end
            S_DRAIN: begin
               acc        <= acc_sum;
               nm_we      <= 1'b1;
               nm_wr_addr <= out_base + j;
               nm_wr_data <= sat_f(relu_f(acc_sum, relu_en));
               state      <= S_WRITE;
            end
            S_WRITE: begin
               acc <= '0;
               j   <= j + 1'b1;
               if ((j + 1'b1) == out_count) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= S_DONE;
               end else begin
                  idx        <= '0;
                  nm_rd_addr <= in_base;
                  w_addr     <= w_addr + 1'b1;
                  state      <= S_FETCH;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mlp_layer_sequencer.sv
// Directed bench for mlp_layer_sequencer with neuron and weight memory models.
module tb_mlp_layer_sequencer;

   localparam int ADDR_W  = 12;
   localparam int DATA_W  = 16;
   localparam int WADDR_W = 16;
   localparam int ACC_W   = 40;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                     reset;
   logic                     start;
   logic [ADDR_W-1:0]        cfg_in_base, cfg_in_count, cfg_out_base, cfg_out_count;
   logic [WADDR_W-1:0]       cfg_w_base;
   logic                     cfg_relu;
   logic [ADDR_W-1:0]        nm_rd_addr, nm_wr_addr;
   logic signed [DATA_W-1:0] nm_rd_data, nm_wr_data, w_data;
   logic                     nm_we;
   logic [WADDR_W-1:0]       w_addr;
   logic                     busy, done, cfg_err;

   mlp_layer_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WADDR_W(WADDR_W), .ACC_W(ACC_W)) dut (
      .clk(clk), .reset(reset), .start(start),
      .cfg_in_base(cfg_in_base), .cfg_in_count(cfg_in_count),
      .cfg_out_base(cfg_out_base), .cfg_out_count(cfg_out_count),
      .cfg_w_base(cfg_w_base), .cfg_relu(cfg_relu),
      .nm_rd_addr(nm_rd_addr), .nm_rd_data(nm_rd_data),
      .nm_we(nm_we), .nm_wr_addr(nm_wr_addr), .nm_wr_data(nm_wr_data),
      .w_addr(w_addr), .w_data(w_data),
      .busy(busy), .done(done), .cfg_err(cfg_err)
   );

   logic signed [DATA_W-1:0] nm [0:4095];
   logic signed [DATA_W-1:0] wm [0:65535];
   logic                     tb_we = 1'b0;
   logic [ADDR_W-1:0]        tb_addr = '0;
   logic signed [DATA_W-1:0] tb_data = '0;

   int                       cyc = 0;
   int                       wl_n = 0;
   logic [ADDR_W-1:0]        wl_addr [0:63];
   logic signed [DATA_W-1:0] wl_data [0:63];
   int                       wl_cyc  [0:63];

   always @(posedge clk) begin
      cyc        <= cyc + 1;
      nm_rd_data <= nm[nm_rd_addr];
      w_data     <= wm[w_addr];
      if (nm_we) begin
         nm[nm_wr_addr]       <= nm_wr_data;
         wl_addr[wl_n[5:0]]   <= nm_wr_addr;
         wl_data[wl_n[5:0]]   <= nm_wr_data;
         wl_cyc[wl_n[5:0]]    <= cyc;
         wl_n                 <= wl_n + 1;
      end else if (tb_we) begin
         nm[tb_addr] <= tb_data;
      end
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic load_nm(input logic [ADDR_W-1:0] a, input logic signed [DATA_W-1:0] d);
      tb_addr = a;
      tb_data = d;
      tb_we   = 1'b1;
      @(posedge clk);
      #1;
      tb_we   = 1'b0;
   endtask

   task automatic set_cfg(input logic [ADDR_W-1:0] ib, input logic [ADDR_W-1:0] ic,
                          input logic [ADDR_W-1:0] ob, input logic [ADDR_W-1:0] oc,
                          input logic [WADDR_W-1:0] wb, input logic relu);
      cfg_in_base   = ib;
      cfg_in_count  = ic;
      cfg_out_base  = ob;
      cfg_out_count = oc;
      cfg_w_base    = wb;
      cfg_relu      = relu;
   endtask

   task automatic pulse_start(output int t);
      @(posedge clk);
      #1;
      start = 1'b1;
      t = cyc;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Bounded wait; returns done latency relative to t (-1 on timeout).
   task automatic wait_done(input int t, output int dlat, output bit busy_ok, output bit err_seen);
      dlat = -1;
      busy_ok = 1'b1;
      err_seen = 1'b0;
      for (int n = 0; n < 2000; n++) begin
         if (cfg_err) err_seen = 1'b1;
         if (done) begin
            if (busy) busy_ok = 1'b0;
            dlat = cyc - t;
            break;
         end
         if (!busy) busy_ok = 1'b0;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic load_multi();
      logic signed [DATA_W-1:0] wv [0:14];
      logic [WADDR_W-1:0] wa;
      wv = '{16'sd1, 16'sd1, 16'sd1, 16'sd1, 16'sd0,
             16'sd2, -16'sd1, 16'sd3, 16'sd4, -16'sd5,
             -16'sd1000, 16'sd500, 16'sd20, 16'sd30, 16'sd7};
      wa = 16'd65530;
      for (int k = 0; k < 15; k++) begin
         wm[wa] = wv[k];
         wa = wa + 1'b1;
      end
      load_nm(12'd4094, 16'sd2);
      load_nm(12'd4095, -16'sd3);
      load_nm(12'd0, 16'sd100);
      load_nm(12'd1, -16'sd50);
      set_cfg(12'd4094, 12'd4, 12'd100, 12'd3, 16'd65530, 1'b0);
   endtask

   task automatic load_single();
      load_nm(12'd0, 16'sd7);
      load_nm(12'd1, 16'sd3);
      load_nm(12'd2, -16'sd8);
      load_nm(12'd3, 16'sd5);
      wm[0] = 16'sd1; wm[1] = 16'sd2; wm[2] = 16'sd3; wm[3] = 16'sd4; wm[4] = 16'sd10;
      set_cfg(12'd0, 12'd4, 12'd16, 12'd1, 16'd0, 1'b1);
   endtask

   task automatic check_multi_writes(input int base, input int t, input string tag);
      int exp_v [0:2];
      exp_v = '{49, 102, -2993};
      n_checks++;
      if (wl_n - base !== 3) begin
         n_fail++;
         $display("FAIL %s_count: got %0d writes, expected 3", tag, wl_n - base);
      end
      for (int e = 0; e < 3; e++) begin
         n_checks++;
         if (wl_addr[(base+e) % 64] !== 12'(100 + e) || wl_data[(base+e) % 64] !== 16'(exp_v[e]) ||
             wl_cyc[(base+e) % 64] - t !== 7 * (e + 1)) begin
            n_fail++;
            $display("FAIL %s_write%0d: got addr %0d data %0d at t+%0d, expected addr %0d data %0d at t+%0d",
                     tag, e, wl_addr[(base+e) % 64], wl_data[(base+e) % 64], wl_cyc[(base+e) % 64] - t,
                     100 + e, exp_v[e], 7 * (e + 1));
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      start = 1'b0;
      set_cfg('0, '0, '0, '0, '0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if ({busy, done, cfg_err, nm_we} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_ctrl: got busy/done/cfg_err/we=%b, expected 0000", {busy, done, cfg_err, nm_we});
      end
      n_checks++;
      if (nm_rd_addr !== '0 || nm_wr_addr !== '0 || nm_wr_data !== '0 || w_addr !== '0) begin
         n_fail++;
         $display("FAIL reset_data: got rd=%0d wr=%0d wd=%0d wa=%0d, expected all 0",
                  nm_rd_addr, nm_wr_addr, nm_wr_data, w_addr);
      end
      reset = 1'b0;
   endtask

   task automatic test_single();
      int t, dlat, base;
      bit bok, err;
      load_single();
      base = wl_n;
      pulse_start(t);
      n_checks++;
      if (busy !== 1'b1 || nm_rd_addr !== 12'd0 || w_addr !== 16'd0) begin
         n_fail++;
         $display("FAIL single_first_fetch: got busy=%b rd=%0d wa=%0d, expected 1 0 0", busy, nm_rd_addr, w_addr);
      end
      wait_done(t, dlat, bok, err);
      n_checks++;
      if (dlat !== 8) begin
         n_fail++;
         $display("FAIL single_done_latency: got %0d, expected 8", dlat);
      end
      n_checks++;
      if (!bok) begin
         n_fail++;
         $display("FAIL single_busy: got busy profile wrong, expected high until done");
      end
      n_checks++;
      if (nm[16] !== 16'sd19 || wl_n - base !== 1 || wl_cyc[base % 64] - t !== 7) begin
         n_fail++;
         $display("FAIL single_result: got mem16=%0d writes=%0d at t+%0d, expected 19 1 t+7",
                  nm[16], wl_n - base, wl_cyc[base % 64] - t);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL single_idle_after: got busy=%b done=%b, expected 0 0", busy, done);
      end
   endtask

   task automatic test_relu();
      int t, dlat;
      bit bok, err;
      wm[0] = -16'sd1; wm[1] = -16'sd1; wm[2] = -16'sd1; wm[3] = -16'sd1; wm[4] = 16'sd0;
      for (int r = 1; r >= 0; r--) begin
         set_cfg(12'd0, 12'd4, 12'd16, 12'd1, 16'd0, r[0]);
         pulse_start(t);
         wait_done(t, dlat, bok, err);
         n_checks++;
         if (nm[16] !== (r == 1 ? 16'sd0 : -16'sd7) || dlat !== 8) begin
            n_fail++;
            $display("FAIL relu%0d: got mem16=%0d latency %0d, expected %0d latency 8",
                     r, nm[16], dlat, (r == 1) ? 0 : -7);
         end
      end
   endtask

   task automatic test_saturation();
      int t, dlat;
      bit bok, err;
      load_nm(12'd0, 16'sd32767);
      load_nm(12'd1, 16'sd32767);
      wm[0] = 16'sd32767; wm[1] = 16'sd32767; wm[2] = 16'sd0;
      set_cfg(12'd0, 12'd2, 12'd16, 12'd1, 16'd0, 1'b0);
      pulse_start(t);
      wait_done(t, dlat, bok, err);
      n_checks++;
      if (nm[16] !== 16'sd32767 || dlat !== 6) begin
         n_fail++;
         $display("FAIL sat_pos: got %0d latency %0d, expected 32767 latency 6", nm[16], dlat);
      end
      wm[0] = -16'sd32767; wm[1] = -16'sd32767;
      pulse_start(t);
      wait_done(t, dlat, bok, err);
      n_checks++;
      if (nm[16] !== -16'sd32768) begin
         n_fail++;
         $display("FAIL sat_neg: got %0d, expected -32768", nm[16]);
      end
   endtask

   task automatic test_multi_wrap();
      int t, dlat, base;
      bit bok, err;
      load_multi();
      base = wl_n;
      pulse_start(t);
      wait_done(t, dlat, bok, err);
      n_checks++;
      if (dlat !== 22 || !bok) begin
         n_fail++;
         $display("FAIL multi_done: got latency %0d busy_ok=%b, expected 22 1", dlat, bok);
      end
      check_multi_writes(base, t, "multi");
   endtask

   task automatic test_reject();
      int t;
      logic [ADDR_W-1:0] ib [0:2];
      logic [ADDR_W-1:0] ic [0:2];
      logic [ADDR_W-1:0] ob [0:2];
      ib = '{12'd0, 12'd0, 12'd4094};
      ic = '{12'd0, 12'd8, 12'd4};
      ob = '{12'd16, 12'd4, 12'd0};
      for (int k = 0; k < 3; k++) begin
         set_cfg(ib[k], ic[k], ob[k], 12'd1, 16'd0, 1'b0);
         pulse_start(t);
         n_checks++;
         if (cfg_err !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reject%0d_pulse: got cfg_err=%b busy=%b, expected 1 0", k, cfg_err, busy);
         end
         @(posedge clk);
         #1;
         n_checks++;
         if (cfg_err !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reject%0d_after: got cfg_err=%b busy=%b, expected 0 0", k, cfg_err, busy);
         end
      end
   endtask

   task automatic test_start_while_busy();
      int t, dlat, base;
      bit bok, err;
      load_single();
      base = wl_n;
      pulse_start(t);
      set_cfg(12'd0, 12'd0, 12'd200, 12'd1, 16'd0, 1'b0);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      set_cfg(12'd8, 12'd2, 12'd200, 12'd2, 16'd0, 1'b0);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      n_checks++;
      if (cfg_err !== 1'b0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL busy_ignore_err: got cfg_err=%b busy=%b, expected 0 1", cfg_err, busy);
      end
      wait_done(t, dlat, bok, err);
      n_checks++;
      if (dlat !== 8 || err || nm[16] !== 16'sd19 || wl_n - base !== 1 || wl_addr[base % 64] !== 12'd16) begin
         n_fail++;
         $display("FAIL busy_ignore_result: got latency %0d err=%b mem16=%0d writes=%0d, expected 8 0 19 1",
                  dlat, err, nm[16], wl_n - base);
      end
      repeat (12) @(posedge clk);
      #1;
      n_checks++;
      if (wl_n - base !== 1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL busy_ignore_no_relaunch: got writes=%0d busy=%b, expected 1 0", wl_n - base, busy);
      end
   endtask

   task automatic test_reset_mid();
      int t, dlat, base;
      bit bok, err;
      load_multi();
      base = wl_n;
      pulse_start(t);
      for (int n = 0; n < 100 && cyc < t + 10; n++) begin
         @(posedge clk);
         #1;
      end
      reset = 1'b1;
      @(posedge clk);
      #1;
      n_checks++;
      if ({busy, done, cfg_err, nm_we} !== 4'b0000 || nm_rd_addr !== '0 || nm_wr_addr !== '0 ||
          nm_wr_data !== '0 || w_addr !== '0) begin
         n_fail++;
         $display("FAIL midreset_outputs: got ctrl=%b rd=%0d wr=%0d wd=%0d wa=%0d, expected all 0",
                  {busy, done, cfg_err, nm_we}, nm_rd_addr, nm_wr_addr, nm_wr_data, w_addr);
      end
      reset = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      n_checks++;
      if (wl_n - base !== 1 || wl_addr[base % 64] !== 12'd100 || wl_data[base % 64] !== 16'sd49) begin
         n_fail++;
         $display("FAIL midreset_writes: got %0d writes first addr %0d data %0d, expected 1 write 100 49",
                  wl_n - base, wl_addr[base % 64], wl_data[base % 64]);
      end
      base = wl_n;
      pulse_start(t);
      wait_done(t, dlat, bok, err);
      n_checks++;
      if (dlat !== 22) begin
         n_fail++;
         $display("FAIL midreset_restart_done: got latency %0d, expected 22", dlat);
      end
      check_multi_writes(base, t, "restart");
   endtask

   initial begin
      test_reset();
      test_single();
      test_relu();
      test_saturation();
      test_multi_wrap();
      test_reject();
      test_start_while_busy();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
